// File: rtl/radix4_feeder.sv
// First DIF stage feeder for a 16-point radix-4 FFT: buffers one frame of
// complex Q1.15 samples, then issues four butterfly groups with twiddles.
module radix4_feeder (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] IN_DATA,
  output logic [31:0] A0,
  output logic [31:0] A1,
  output logic [31:0] A2,
  output logic [31:0] A3,
  output logic [31:0] W1K,
  output logic [31:0] W2K,
  output logic [31:0] W3K,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [1:0]  OUT_GROUP,
  output logic        OUT_LAST
);

  typedef enum logic {FILL, ISSUE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  wr_cnt_q, wr_cnt_d;
  logic [1:0]  k_q, k_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic [31:0] a_q [4];
  logic [31:0] a_d [4];
  logic [31:0] w_q [3];
  logic [31:0] w_d [3];
  logic [31:0] mem_q [16];

  logic        wr_en;
  logic        load;
  logic [1:0]  load_k;

  // W16^m = cos(2*pi*m/16) - j*sin(2*pi*m/16), Q1.15, +1.0 saturated, -1.0 as 0x8001
  function automatic logic [31:0] twiddle(input logic [3:0] m);
    case (m)
      4'd0:    twiddle = 32'h7FFF_0000;
      4'd1:    twiddle = 32'h7642_CF04;
      4'd2:    twiddle = 32'h5A82_A57E;
      4'd3:    twiddle = 32'h30FC_89BE;
      4'd4:    twiddle = 32'h0000_8001;
      4'd5:    twiddle = 32'hCF04_89BE;
      4'd6:    twiddle = 32'hA57E_A57E;
      4'd7:    twiddle = 32'h89BE_CF04;
      4'd8:    twiddle = 32'h8001_0000;
      4'd9:    twiddle = 32'h89BE_30FC;
      default: twiddle = '0;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    k_d         = k_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    a_d         = a_q;
    w_d         = w_q;
    wr_en       = 1'b0;
    load        = 1'b0;
    load_k      = 2'd0;

    unique case (state_q)
      FILL: begin
        in_ready_d = 1'b1;
        if (IN_VALID && in_ready_q) begin
          wr_en    = 1'b1;
          wr_cnt_d = wr_cnt_q + 4'd1;
          // Group 0 never reads x[15], so it can load on the same edge x[15] is written.
          if (wr_cnt_q == 4'd15) begin
            state_d     = ISSUE;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            load        = 1'b1;
            load_k      = 2'd0;
          end
        end
      end
      ISSUE: begin
        if (out_valid_q && OUT_READY) begin
          if (k_q == 2'd3) begin
            state_d     = FILL;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            in_ready_d  = 1'b1;
            k_d         = 2'd0;
          end else begin
            load   = 1'b1;
            load_k = k_q + 2'd1;
          end
        end
      end
      default: state_d = FILL;
    endcase

    if (load) begin
      k_d        = load_k;
      out_last_d = (load_k == 2'd3);
      for (int unsigned i = 0; i < 4; i++) begin
        a_d[i] = mem_q[{2'(i), load_k}];
      end
      w_d[0] = twiddle({2'b00, load_k});
      w_d[1] = twiddle({1'b0, load_k, 1'b0});
      w_d[2] = twiddle({2'b00, load_k} + {1'b0, load_k, 1'b0});
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= FILL;
      wr_cnt_q    <= '0;
      k_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) a_q[i] <= '0;
      for (int unsigned i = 0; i < 3; i++) w_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      k_q         <= k_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      a_q         <= a_d;
      w_q         <= w_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_cnt_q] <= IN_DATA;
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_GROUP = k_q;
  assign OUT_LAST  = out_last_q;
  assign A0        = a_q[0];
  assign A1        = a_q[1];
  assign A2        = a_q[2];
  assign A3        = a_q[3];
  assign W1K       = w_q[0];
  assign W2K       = w_q[1];
  assign W3K       = w_q[2];

endmodule

// File: tb/tb_radix4_feeder.sv
// Randomized self-checking bench for radix4_feeder against a frame-level
// reference model with twiddles computed from cos/sin.
module tb_radix4_feeder;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [31:0] IN_DATA = '0;
  logic [31:0] A0, A1, A2, A3, W1K, W2K, W3K;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [1:0]  OUT_GROUP;
  logic        OUT_LAST;

  radix4_feeder dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .A0(A0), .A1(A1), .A2(A2), .A3(A3),
    .W1K(W1K), .W2K(W2K), .W3K(W3K),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_GROUP(OUT_GROUP), .OUT_LAST(OUT_LAST)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the current frame plus handshake expectations
  logic [31:0] frame [16];
  int filled, sent, frames_done;
  bit rdy_exp, vld_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] q15(input real v);
    int i;
    i = $rtoi($floor(v * 32768.0 + 0.5));
    if (i > 32767)  i = 32767;
    if (i < -32767) i = -32767;
    return 16'(i);
  endfunction

  function automatic logic [31:0] tw(input int m);
    real a;
    a = 2.0 * 3.14159265358979 * m / 16.0;
    return {q15($cos(a)), q15(-$sin(a))};
  endfunction

  task automatic model_reset();
    filled = 0; sent = 0; rdy_exp = 0; vld_exp = 0;
  endtask

  task automatic check_outputs();
    int k;
    chk("in_ready", {31'd0, IN_READY}, {31'd0, rdy_exp});
    chk("out_valid", {31'd0, OUT_VALID}, {31'd0, vld_exp});
    if (vld_exp) begin
      k = sent;
      chk("a0", A0, frame[k]);
      chk("a1", A1, frame[k+4]);
      chk("a2", A2, frame[k+8]);
      chk("a3", A3, frame[k+12]);
      chk("w1k", W1K, tw(k));
      chk("w2k", W2K, tw(2*k));
      chk("w3k", W3K, tw(3*k));
      chk("group", {30'd0, OUT_GROUP}, 32'(k));
      chk("last", {31'd0, OUT_LAST}, {31'd0, (k == 3)});
    end
  endtask

  task automatic cycle(input bit iv, input logic [31:0] d, input bit ordy);
    check_outputs();
    IN_VALID = iv; IN_DATA = d; OUT_READY = ordy;
    @(posedge CLK);
    if (vld_exp) begin
      if (ordy) begin
        sent++;
        if (sent == 4) begin
          vld_exp = 0; rdy_exp = 1; filled = 0; frames_done++;
        end
      end
    end else if (rdy_exp && iv) begin
      frame[filled] = d;
      filled++;
      if (filled == 16) begin
        vld_exp = 1; rdy_exp = 0; sent = 0;
      end
    end else begin
      rdy_exp = 1;
    end
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, {31'd0, IN_READY}, '0);
    chk({tag, "_out_valid"}, {31'd0, OUT_VALID}, '0);
    chk({tag, "_last"}, {31'd0, OUT_LAST}, '0);
    chk({tag, "_group"}, {30'd0, OUT_GROUP}, '0);
    chk({tag, "_a0"}, A0, '0);
    chk({tag, "_a1"}, A1, '0);
    chk({tag, "_a2"}, A2, '0);
    chk({tag, "_a3"}, A3, '0);
    chk({tag, "_w1k"}, W1K, '0);
    chk({tag, "_w2k"}, W2K, '0);
    chk({tag, "_w3k"}, W3K, '0);
  endtask

  task automatic reset_mid(input string tag);
    RST_N = 1'b0;
    #1;
    chk_zero(tag);
    #2;
    RST_N = 1'b1;
    model_reset();
  endtask

  task automatic run_frame(input int pv, input int pr);
    int start;
    int budget;
    start = frames_done;
    budget = 0;
    while (frames_done == start && budget < 400) begin
      cycle(($urandom_range(99) < pv), $urandom, ($urandom_range(99) < pr));
      budget++;
    end
    if (frames_done == start) chk("frame_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lows;
    frames_done = 0;
    model_reset();
    #3;
    chk_zero("reset");
    #9;
    RST_N = 1'b1;
    cycle(0, $urandom, 0);

    // Ramp frame, full throughput
    for (int n = 0; n < 16; n++) cycle(1, {16'(n), 16'(n)}, 1);
    cycle(0, $urandom, 1);
    chk("ramp_w1k", W1K, 32'h7642_CF04);
    chk("ramp_w2k", W2K, 32'h5A82_A57E);
    chk("ramp_w3k", W3K, 32'h30FC_89BE);
    chk("ramp_a1", A1, {16'd5, 16'd5});
    for (int n = 0; n < 4; n++) cycle(0, $urandom, 1);

    // Backpressure held at k=2
    for (int n = 0; n < 16; n++) cycle(1, $urandom, 1);
    cycle(0, $urandom, 1);
    cycle(0, $urandom, 1);
    chk("bp_w1k", W1K, 32'h5A82_A57E);
    chk("bp_w2k", W2K, 32'h0000_8001);
    chk("bp_w3k", W3K, 32'hA57E_A57E);
    for (int n = 0; n < 5; n++) cycle($urandom_range(1), $urandom, 0);
    for (int n = 0; n < 3; n++) cycle(0, $urandom, 1);

    // Gapped input
    run_frame(50, 100);
    cycle(0, $urandom, 1);

    // Back-to-back frames
    lows = 0;
    for (int n = 0; n < 36; n++) begin
      if (!IN_READY) lows++;
      cycle(1, $urandom, 1);
    end
    chk("b2b_gap", 32'(lows), 32'd4);
    for (int n = 0; n < 5; n++) cycle(0, $urandom, 1);

    // Reset after 9 samples, then a clean frame
    for (int n = 0; n < 9; n++) cycle(1, $urandom, 1);
    reset_mid("rst_fill");
    run_frame(100, 100);

    // Reset while groups are still pending
    for (int n = 0; n < 16; n++) cycle(1, $urandom, 1);
    cycle(0, $urandom, 1);
    reset_mid("rst_issue");
    run_frame(80, 100);

    // Random valid/ready mix
    for (int f = 0; f < 4; f++) run_frame(70, 60);
    cycle(0, $urandom, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
